mmio_console: RTL

- Memory-mapped console and halt peripheral snooping the core's data-memory request channel.
- Provides NUM_CHAN byte-wide TX channels. Each channel has a FIFO with a valid/ready drain port and a readable status register.
- Provides a halt register that latches a 32-bit exit code. Halt optionally waits until all FIFOs have drained.
- Sits beside data memory in the top level. With default parameters its addresses are 0x0002_FFF8 (console) and 0x0002_FFFC (halt).

---
 rtl/mmio_console_if.sv | 21 ++
 rtl/mmio_console.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mmio_console_if.sv
// Data-memory request/response channel that mmio_console snoops beside data memory.
interface mmio_console_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_do_write;
    logic        req_do_read;
    logic [31:0] req_data;
    logic        hit;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_do_write, req_do_read, req_data,
        input  hit, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_do_write, req_do_read, req_data,
        output hit, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console (per-channel byte FIFOs with status) and halt/exit-code register.
// Channel ch lives at CONSOLE_ADDR - 8*ch (TXDATA) and 4 bytes below that (STATUS).
module mmio_console #(
    parameter int          NUM_CHAN     = 1,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0002_FFF8,
    parameter logic [31:0] HALT_ADDR    = 32'h0002_FFFC,
    parameter bit          HALT_DRAIN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_console_if.slave         bus,
    output logic [NUM_CHAN-1:0]   tx_valid,
    output logic [8*NUM_CHAN-1:0] tx_data,
    input  logic [NUM_CHAN-1:0]   tx_ready,
    output logic                  halt,
    output logic [31:0]           exit_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_CHAN-1:0] tx_hit;
    logic [NUM_CHAN-1:0] st_hit;
    logic [NUM_CHAN-1:0] st_read;
    logic [31:0]         chan_status [NUM_CHAN];
    logic                halt_hit;
    logic                halt_write;
    logic                any_hit;
    logic                rsp_valid_next;
    logic [31:0]         rsp_data_next;

    assign halt_hit   = bus.req_valid && (bus.req_addr == HALT_ADDR);
    assign halt_write = halt_hit && (bus.req_do_write == 4'b1111) && (state == RUN);
    assign st_read    = st_hit & {NUM_CHAN{bus.req_do_read}};
    assign any_hit    = halt_hit || (|tx_hit) || (|st_hit);
    assign bus.hit    = any_hit;
    assign halt       = (state == HALTED);

    for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_chan
        logic [7:0]    mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] count;
        logic          overflow;
        logic          full;
        logic          pop;
        logic          push_req;
        logic          push_ok;

        assign tx_hit[ch] = bus.req_valid && (bus.req_addr == CONSOLE_ADDR - 32'(8 * ch));
        assign st_hit[ch] = bus.req_valid && (bus.req_addr == CONSOLE_ADDR - 32'(8 * ch + 4));

        assign full     = (count == CW'(FIFO_DEPTH));
        assign pop      = tx_valid[ch] && tx_ready[ch];
        assign push_req = tx_hit[ch] && bus.req_do_write[0] && (state == RUN);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        assign push_ok  = push_req && (!full || pop);

        assign tx_valid[ch]         = (count != '0);
        assign tx_data[8*ch +: 8]   = mem[rd_ptr];
        assign chan_status[ch]      = {16'h0000, 8'(count), 4'h0, (state == DRAIN),
                                       overflow, full, (count == '0)};

        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wr_ptr] <= bus.req_data[7:0];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push_ok) begin
                    count <= count - 1'b1;
                end
                // A fresh overflow wins over the clear-on-read of the same cycle.
                if (push_req && full && !pop) begin
                    overflow <= 1'b1;
                end else if (st_read[ch]) begin
                    overflow <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rsp_valid_next = 1'b0;
        rsp_data_next  = 32'h0;
        if (bus.req_do_read && any_hit) begin
            rsp_valid_next = 1'b1;
            for (int ch = 0; ch < NUM_CHAN; ch++) begin
                if (st_hit[ch]) begin
                    rsp_data_next = chan_status[ch];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 32'h0;
            exit_code     <= 32'h0;
        end else begin
            bus.rsp_valid <= rsp_valid_next;
            bus.rsp_data  <= rsp_data_next;
            if (halt_write) begin
                exit_code <= bus.req_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (halt_write) begin
                    if (HALT_DRAIN) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = HALTED;
                    end
                end
            end
            DRAIN: begin
                if (tx_valid == '0) begin
                    state_next = HALTED;
                end
            end
            default: state_next = state;
        endcase
    end
endmodule
